// File: rtl/alu_srcb_stage.sv
// alu_srcb_stage: registered ALU operand-B source selector.
// Resolves one of NSRC packed source words (or an internal constant), waits
// for the chosen source to be ready, and queues the operand in a 2-entry
// valid/ready skid buffer toward the ALU.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready capture request / stage can accept (registered)
//   sel                 source select, sampled with in_valid
//   src_bus, src_rdy    packed source words and per-source ready flags
//   out_valid/out_ready operand available / ALU consumes
//   out_data            head-of-buffer operand
//   err, err_clr        sticky illegal-select flag and its clear
//   stall_cnt           saturating count of cycles stalled on src_rdy
module alu_srcb_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 5,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_SEL = 1,
  parameter int unsigned CONST_VAL = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [NSRC-1:0]       src_rdy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Second skid entry; the head entry is out_valid/out_data themselves.
  logic             vld1_q;
  logic [WIDTH-1:0] data1_q;

  // Resolved select
  logic [WIDTH-1:0] res_val;
  logic             res_ok;
  logic             res_ill;

  // Next-state values
  logic             vld0_d;
  logic [WIDTH-1:0] data0_d;
  logic             vld1_d;
  logic [WIDTH-1:0] data1_d;
  logic             in_ready_d;
  logic             err_d;
  logic [CNT_W-1:0] stall_d;

  logic req;
  logic accept;
  logic stall_ev;
  logic pop;

  // Source resolution: constant code first, then legal slices, else illegal.
  always_comb begin
    res_val = '0;
    res_ok  = 1'b1;
    res_ill = 1'b1;
    if (sel == SEL_W'(CONST_SEL)) begin
      res_val = WIDTH'(CONST_VAL);
      res_ill = 1'b0;
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (sel == SEL_W'(i)) begin
          res_val = src_bus[i*WIDTH +: WIDTH];
          res_ok  = src_rdy[i];
          res_ill = 1'b0;
        end
      end
    end
  end

  // Next-state: skid buffer shift, error flag, stall counter.
  always_comb begin
    vld0_d     = out_valid;
    data0_d    = out_data;
    vld1_d     = vld1_q;
    data1_d    = data1_q;
    err_d      = err;
    stall_d    = stall_cnt;

    req      = in_valid & in_ready;
    accept   = req & res_ok;
    stall_ev = req & ~res_ok;
    pop      = out_valid & out_ready;

    if (pop) begin
      vld0_d  = vld1_q;
      data0_d = data1_q;
      vld1_d  = 1'b0;
    end

    // Push lands in the first free slot after any pop; never pushes when full.
    if (accept) begin
      if (vld0_d) begin
        vld1_d  = 1'b1;
        data1_d = res_val;
      end else begin
        vld0_d  = 1'b1;
        data0_d = res_val;
      end
    end

    // Registered ready: only depends on next occupancy, never on out_ready now.
    in_ready_d = ~vld1_d;

    // Set beats clear.
    if (req && res_ill) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    if (stall_ev && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_d = stall_cnt + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      vld1_q    <= 1'b0;
      data1_q   <= '0;
      in_ready  <= 1'b1;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      out_valid <= vld0_d;
      out_data  <= data0_d;
      vld1_q    <= vld1_d;
      data1_q   <= data1_d;
      in_ready  <= in_ready_d;
      err       <= err_d;
      stall_cnt <= stall_d;
    end
  end

endmodule

// File: tb/tb_alu_srcb_stage.sv
// tb_alu_srcb_stage: self-checking bench for alu_srcb_stage (CNT_W=4 build so
// stall saturation is reachable). A queue-based operand model runs every cycle;
// table vectors and hand sequences add explicit expectations.
module tb_alu_srcb_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned CW = 4;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     sel;
  logic [N*W-1:0] src_bus;
  logic [N-1:0]   src_rdy;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           err;
  logic           err_clr;
  logic [CW-1:0]  stall_cnt;

  alu_srcb_stage #(
    .WIDTH(W), .NSRC(N), .SEL_W(3), .CONST_SEL(1), .CONST_VAL(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src_bus(src_bus), .src_rdy(src_rdy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err(err), .err_clr(err_clr),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] q[$];
  bit          m_err;
  int          m_stall;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_model();
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (q.size() > 0) chk("m_out_data", out_data, q[0]);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
  endtask

  // One clock: evaluate the spec rules on the pre-edge inputs, advance, check.
  task automatic cyc();
    logic [31:0] v;
    bit ok, ill, room, acc, pop;
    room = (q.size() < 2);
    ill  = (sel != 3'd1) && (int'(sel) >= int'(N));
    if (sel == 3'd1) begin
      v = 32'd4; ok = 1'b1;
    end else if (ill) begin
      v = 32'd0; ok = 1'b1;
    end else begin
      v = src_bus[int'(sel)*32 +: 32]; ok = src_rdy[sel];
    end
    acc = in_valid && room && ok;
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (in_valid && room && !ok && m_stall < (1 << CW) - 1) m_stall++;
    if (in_valid && room && ill) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(v);
    #1;
    check_model();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  // Mid-cycle asynchronous reset, checked before any clock edge.
  task automatic mid_reset();
    #3;
    reset = 1'b1;
    #1;
    check_reset_state();
    idle();
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = 3'd0;
    src_bus   = '0;
    src_rdy   = '1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    model_clear();

    tbl[0] = '{3'd0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{3'd2, 32'h22222222, 1'b0};
    tbl[2] = '{3'd3, 32'h33333333, 1'b0};
    tbl[3] = '{3'd1, 32'h00000004, 1'b0};
    tbl[4] = '{3'd4, 32'hCAFE0000, 1'b0};
    tbl[5] = '{3'd6, 32'h00000000, 1'b1};
    tbl[6] = '{3'd0, 32'hDEADBEEF, 1'b1};
    tbl[7] = '{3'd7, 32'h00000000, 1'b1};
    tbl[8] = '{3'd5, 32'h00000000, 1'b1};

    #1;
    check_reset_state();
    #11;
    reset = 1'b0;
    cyc();

    // Back-to-back captures, one operand per cycle in order
    src_bus = {32'hCAFE0000, 32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF};
    src_rdy = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      sel      = tbl[i].sel;
      cyc();
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_out_data", out_data, tbl[i].exp_data);
      chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
    end
    idle();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    cyc();

    // Stall on source 4 for three cycles, then capture; then saturate
    mid_reset();
    cyc();
    in_valid = 1'b1;
    sel      = 3'd4;
    src_rdy  = 5'b01111;
    repeat (3) cyc();
    chk("stall3_cnt", 32'(stall_cnt), 32'd3);
    chk("stall3_valid", 32'(out_valid), 32'd0);
    src_rdy = '1;
    cyc();
    chk("stall_cap_data", out_data, 32'hCAFE0000);
    chk("stall_cap_valid", 32'(out_valid), 32'd1);
    src_rdy = 5'b01111;
    repeat (14) cyc();
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    src_rdy = '1;
    idle();
    cyc();

    // Fill the buffer with the ALU stalled; third request ignored
    mid_reset();
    cyc();
    out_ready = 1'b0;
    src_bus   = {32'hCAFE0000, 32'h33333333, 32'h0000000B, 32'h12345678, 32'h0000000A};
    in_valid  = 1'b1;
    sel       = 3'd0;
    cyc();
    chk("fill1_in_ready", 32'(in_ready), 32'd1);
    sel = 3'd2;
    cyc();
    chk("fill2_in_ready", 32'(in_ready), 32'd0);
    sel     = 3'd3;
    src_rdy = 5'b10111;
    repeat (3) cyc();
    chk("full_hold_data", out_data, 32'h0000000A);
    chk("full_no_stall", 32'(stall_cnt), 32'd0);
    src_rdy   = '1;
    idle();
    out_ready = 1'b1;
    cyc();
    chk("drain1_data", out_data, 32'h0000000B);
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("drain2_valid", 32'(out_valid), 32'd0);

    // Illegal select, set-wins-over-clear, then clear
    in_valid = 1'b1;
    sel      = 3'd6;
    cyc();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_data", out_data, 32'd0);
    err_clr = 1'b1;
    cyc();
    chk("ill_setwins", 32'(err), 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("ill_clr", 32'(err), 32'd0);
    err_clr = 1'b0;

    // Async reset while holding two entries, err set and stalls counted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd6;
    cyc();
    sel     = 3'd4;
    src_rdy = 5'b01111;
    cyc();
    src_rdy = '1;
    sel     = 3'd0;
    cyc();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    mid_reset();
    out_ready = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      src_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      src_rdy   = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
